// File: rtl/stg00_sum_diff_serializer.sv
// rtl/stg00_sum_diff_serializer.sv - FFT stage-00 sum/diff to single-stream serializer
//
// Purpose:
//    Forwards the 16-lane stage-00 sum outputs with one cycle of latency and
//    captures the matching diff lanes into a BURST_LEN-deep buffer. Once a
//    full burst has been written, the buffered diffs are replayed for exactly
//    BURST_LEN cycles. Stage 01 therefore sees a single stream of BURST_LEN
//    sum cycles followed by BURST_LEN diff cycles.
//
// Ports:
//    clk          system clock
//    rstn         asynchronous active-low reset
//    in_sum_re    sum lanes, real           [LANES][WIDTH+1]
//    in_sum_im    sum lanes, imag           [LANES][WIDTH+1]
//    in_diff_re   diff lanes, real          [LANES][WIDTH+1]
//    in_diff_im   diff lanes, imag          [LANES][WIDTH+1]
//    in_valid     qualifies all in_* lanes
//    out_re       serialized data, real     [LANES][WIDTH+1]
//    out_im       serialized data, imag     [LANES][WIDTH+1]
//    out_valid    out_re/out_im valid this cycle
//    out_is_diff  0 = sum half, 1 = diff half
//    out_sof      first valid cycle of each sum+diff group
//    ovf_err      sticky: input arrived while draining

module stg00_sum_diff_serializer #(
   parameter int WIDTH     = 9,
   parameter int BURST_LEN = 16,
   parameter int LANES     = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [LANES-1:0][WIDTH:0]    in_sum_re,
   input  logic [LANES-1:0][WIDTH:0]    in_sum_im,
   input  logic [LANES-1:0][WIDTH:0]    in_diff_re,
   input  logic [LANES-1:0][WIDTH:0]    in_diff_im,
   input  logic                         in_valid,
   output logic [LANES-1:0][WIDTH:0]    out_re,
   output logic [LANES-1:0][WIDTH:0]    out_im,
   output logic                         out_valid,
   output logic                         out_is_diff,
   output logic                         out_sof,
   output logic                         ovf_err
);

   localparam int            CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   state_t                      state, nxt_state;
   logic [CW-1:0]               wr_cnt, rd_cnt;

   // Diff buffer: no reset, every entry is rewritten before it is replayed.
   logic [LANES-1:0][WIDTH:0]   diff_buf_re [BURST_LEN];
   logic [LANES-1:0][WIDTH:0]   diff_buf_im [BURST_LEN];

   logic                        wr_en;
   logic                        err_set;
   logic                        nxt_valid, nxt_is_diff, nxt_sof;
   logic [LANES-1:0][WIDTH:0]   nxt_re, nxt_im;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= FILL;
      else       state <= nxt_state;
   end

   // Next-state logic: a burst ends on the write that fills the last slot,
   // a drain ends on the cycle that reads the last slot.
   always_comb begin
      nxt_state = state;
      case (state)
         FILL:    if (in_valid && (wr_cnt == LAST)) nxt_state = DRAIN;
         DRAIN:   if (rd_cnt == LAST)               nxt_state = FILL;
         default: nxt_state = FILL;
      endcase
   end

   // Output logic: values to be registered on the next edge.
   // Data holds its last value when not valid.
   always_comb begin
      nxt_valid   = 1'b0;
      nxt_is_diff = 1'b0;
      nxt_sof     = 1'b0;
      nxt_re      = out_re;
      nxt_im      = out_im;
      wr_en       = 1'b0;
      err_set     = 1'b0;
      case (state)
         FILL: begin
            if (in_valid) begin
               nxt_valid = 1'b1;
               nxt_sof   = (wr_cnt == '0);
               nxt_re    = in_sum_re;
               nxt_im    = in_sum_im;
               wr_en     = 1'b1;
            end
         end
         DRAIN: begin
            nxt_valid   = 1'b1;
            nxt_is_diff = 1'b1;
            nxt_re      = diff_buf_re[rd_cnt];
            nxt_im      = diff_buf_im[rd_cnt];
            // Input during drain is dropped; only the error flag records it.
            err_set     = in_valid;
         end
         default: ;
      endcase
   end

   // Output registers and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_re      <= '0;
         out_im      <= '0;
         out_valid   <= 1'b0;
         out_is_diff <= 1'b0;
         out_sof     <= 1'b0;
         ovf_err     <= 1'b0;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
      end else begin
         out_re      <= nxt_re;
         out_im      <= nxt_im;
         out_valid   <= nxt_valid;
         out_is_diff <= nxt_is_diff;
         out_sof     <= nxt_sof;
         if (err_set) ovf_err <= 1'b1;

         if (wr_en) wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + CW'(1);

         if (state == DRAIN) rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + CW'(1);
         else                rd_cnt <= '0;
      end
   end

   // Diff buffer write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         diff_buf_re[wr_cnt] <= in_diff_re;
         diff_buf_im[wr_cnt] <= in_diff_im;
      end
   end

endmodule

// File: tb/tb_stg00_sum_diff_serializer.sv
// tb/tb_stg00_sum_diff_serializer.sv - scoreboard bench for stg00_sum_diff_serializer

module tb_stg00_sum_diff_serializer;

   localparam int W  = 9;
   localparam int L  = 16;
   localparam int BL = 16;

   typedef logic [L-1:0][W:0] vec_t;

   typedef struct {
      vec_t re;
      vec_t im;
      logic is_diff;
      logic sof;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   vec_t in_sum_re, in_sum_im, in_diff_re, in_diff_im;
   logic in_valid;
   vec_t out_re, out_im;
   logic out_valid, out_is_diff, out_sof, ovf_err;

   int errors = 0;
   int checks = 0;

   exp_t q[$];
   vec_t bdre [BL];
   vec_t bdim [BL];
   int   bcnt = 0;
   int   cur_run = 0;
   int   last_run = 0;

   stg00_sum_diff_serializer #(.WIDTH(W), .BURST_LEN(BL), .LANES(L)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_sum_re   (in_sum_re),
      .in_sum_im   (in_sum_im),
      .in_diff_re  (in_diff_re),
      .in_diff_im  (in_diff_im),
      .in_valid    (in_valid),
      .out_re      (out_re),
      .out_im      (out_im),
      .out_valid   (out_valid),
      .out_is_diff (out_is_diff),
      .out_sof     (out_sof),
      .ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Issue one stage-00 sample and queue the expected output(s).
   task automatic send(input vec_t sre, input vec_t sim, input vec_t dre, input vec_t dim);
      exp_t e;
      in_sum_re  = sre;
      in_sum_im  = sim;
      in_diff_re = dre;
      in_diff_im = dim;
      in_valid   = 1'b1;
      e.re = sre; e.im = sim; e.is_diff = 1'b0; e.sof = (bcnt == 0);
      q.push_back(e);
      bdre[bcnt] = dre;
      bdim[bcnt] = dim;
      bcnt++;
      if (bcnt == BL) begin
         for (int i = 0; i < BL; i++) begin
            e.re = bdre[i]; e.im = bdim[i]; e.is_diff = 1'b1; e.sof = 1'b0;
            q.push_back(e);
         end
         bcnt = 0;
      end
      cycle();
      in_valid = 1'b0;
   endtask

   // Sample k of the ramp pattern; seed shifts values so bursts differ.
   task automatic send_ramp(input int k, input int seed);
      vec_t sre, sim, dre, dim;
      for (int l = 0; l < L; l++) begin
         sre[l] = 10'(16*k + l + seed);
         dre[l] = 10'(-(16*k + l + seed));
         sim[l] = 10'(k - l + seed);
         dim[l] = 10'(3*l - k - seed);
      end
      send(sre, sim, dre, dim);
   endtask

   task automatic send_burst(input int seed);
      for (int k = 0; k < BL; k++) send_ramp(k, seed);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         cur_run++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=out_valid=1 required=no output pending");
         end else begin
            e = q.pop_front();
            chk("out_re",      256'(out_re),      256'(e.re));
            chk("out_im",      256'(out_im),      256'(e.im));
            chk("out_is_diff", 256'(out_is_diff), 256'(e.is_diff));
            chk("out_sof",     256'(out_sof),     256'(e.sof));
         end
      end else if (cur_run != 0) begin
         last_run = cur_run;
         cur_run  = 0;
      end
   end

   initial begin
      vec_t a, b, c;
      rstn       = 1'b0;
      in_valid   = 1'b0;
      in_sum_re  = '0;
      in_sum_im  = '0;
      in_diff_re = '0;
      in_diff_im = '0;
      idle(3);

      // Reset state
      chk("rst_out_valid",   256'(out_valid),   256'(0));
      chk("rst_out_re",      256'(out_re),      256'(0));
      chk("rst_out_im",      256'(out_im),      256'(0));
      chk("rst_out_is_diff", 256'(out_is_diff), 256'(0));
      chk("rst_out_sof",     256'(out_sof),     256'(0));
      chk("rst_ovf_err",     256'(ovf_err),     256'(0));
      rstn = 1'b1;
      idle(2);

      // 1: one contiguous burst -> 32 contiguous outputs
      send_burst(0);
      idle(20);
      chk("t1_run_len", 256'(last_run), 256'(32));

      // 2: two bursts at stage-00 cadence -> 64 contiguous outputs
      send_burst(1);
      idle(16);
      send_burst(40);
      idle(20);
      chk("t2_run_len", 256'(last_run), 256'(64));
      chk("t2_ovf_err", 256'(ovf_err),  256'(0));

      // 3: 3-cycle gap after sample 7
      for (int k = 0; k < 8; k++) send_ramp(k, 5);
      idle(3);
      for (int k = 8; k < BL; k++) send_ramp(k, 5);
      idle(20);
      chk("t3_run_len", 256'(last_run), 256'(24));
      chk("t3_ovf_err", 256'(ovf_err),  256'(0));

      // 4: input on DRAIN cycle 5 is dropped and flags an error
      send_burst(7);
      idle(4);
      for (int l = 0; l < L; l++) begin
         in_sum_re[l]  = 10'h155; in_sum_im[l]  = 10'h0AA;
         in_diff_re[l] = 10'h133; in_diff_im[l] = 10'h0CC;
      end
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("t4_ovf_err_set", 256'(ovf_err), 256'(1));
      idle(20);
      chk("t4_ovf_err_sticky", 256'(ovf_err), 256'(1));
      chk("t4_run_len", 256'(last_run), 256'(32));

      // 5: reset at DRAIN cycle 8
      send_burst(100);
      idle(7);
      rstn = 1'b0;
      q.delete();
      #1;
      chk("t5_out_valid", 256'(out_valid),   256'(0));
      chk("t5_out_re",    256'(out_re),      256'(0));
      chk("t5_out_im",    256'(out_im),      256'(0));
      chk("t5_is_diff",   256'(out_is_diff), 256'(0));
      chk("t5_ovf_err",   256'(ovf_err),     256'(0));
      idle(2);
      rstn = 1'b1;
      idle(1);
      send_burst(200);
      idle(20);

      // 6: extreme values
      for (int l = 0; l < L; l++) begin
         a[l] = 10'h1FF;
         b[l] = 10'h200;
         c[l] = 10'(l * 37 - 300);
      end
      for (int k = 0; k < BL; k++) send(a, b, b, a);
      idle(20);
      for (int k = 0; k < BL; k++) send(c, a, b, c);
      idle(20);

      chk("scoreboard_empty", 256'(q.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
